// File: rtl/rotor_step_sequencer.sv
// Multi-rotor move sequencer: plans the shortest signed path per rotor, then emits paced
// single-step pulses with direction and tracks each rotor's face.
module rotor_step_sequencer #(
    parameter int NUM_ROTORS   = 6,
    parameter int POS_BITS     = 3,
    parameter int STEP_DIV     = 1000,
    parameter int SIMULTANEOUS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [NUM_ROTORS*POS_BITS-1:0] cmd_target,
    input  logic                           abort,
    output logic [NUM_ROTORS-1:0]          step_pulse,
    output logic [NUM_ROTORS-1:0]          step_dir,
    output logic [NUM_ROTORS*POS_BITS-1:0] cur_pos,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted
);

    localparam int                 DIV_W    = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [POS_BITS:0]  HALF     = (POS_BITS + 1)'(1 << (POS_BITS - 1));

    typedef enum logic [1:0] {S_IDLE, S_PLAN, S_WAIT, S_DONE} state_t;

    state_t                           state, state_nxt;
    logic [NUM_ROTORS*POS_BITS-1:0]   target_q;
    logic [POS_BITS-1:0]              pos_q    [NUM_ROTORS];
    logic [POS_BITS-1:0]              rem_q    [NUM_ROTORS];
    logic [POS_BITS-1:0]              rem_nxt  [NUM_ROTORS];
    logic [POS_BITS-1:0]              plan_rem [NUM_ROTORS];
    logic [NUM_ROTORS-1:0]            dir_q, plan_dir, pulse;
    logic [DIV_W-1:0]                 div_q;
    logic                             aborted_q, plan_zero, rem_zero, tick, found;

    // Returns {dir, steps}; a half-turn distance resolves forward.
    function automatic logic [POS_BITS:0] plan_path(input logic [POS_BITS-1:0] tgt,
                                                    input logic [POS_BITS-1:0] cur);
        logic [POS_BITS-1:0] d, d_neg;
        d     = tgt - cur;
        d_neg = '0 - d;
        if ({1'b0, d} <= HALF) plan_path = {1'b1, d};
        else                   plan_path = {1'b0, d_neg};
    endfunction

    always_comb begin
        plan_zero = 1'b1;
        plan_dir  = '0;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            {plan_dir[i], plan_rem[i]} = plan_path(target_q[i*POS_BITS +: POS_BITS], pos_q[i]);
            if (plan_rem[i] != '0) plan_zero = 1'b0;
        end
    end

    // A tick coinciding with abort is swallowed so no pulse escapes after the stop request.
    always_comb begin
        tick     = (state == S_WAIT) && (div_q == DIV_LAST) && !abort;
        pulse    = '0;
        found    = 1'b0;
        rem_zero = 1'b1;
        for (int i = 0; i < NUM_ROTORS; i++) begin
            if (tick && (rem_q[i] != '0) && ((SIMULTANEOUS != 0) || !found)) pulse[i] = 1'b1;
            if (rem_q[i] != '0) found = 1'b1;
            rem_nxt[i] = rem_q[i] - POS_BITS'(pulse[i]);
            if (rem_nxt[i] != '0) rem_zero = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_PLAN;
            S_PLAN:  state_nxt = plan_zero ? S_DONE : S_WAIT;
            S_WAIT:  if (abort || (tick && rem_zero)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_q     <= '0;
            dir_q     <= '0;
            aborted_q <= 1'b0;
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (cmd_valid) aborted_q <= 1'b0;
                S_PLAN: begin
                    dir_q <= plan_dir;
                    div_q <= '0;
                    for (int i = 0; i < NUM_ROTORS; i++) rem_q[i] <= plan_rem[i];
                end
                S_WAIT: begin
                    div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                    if (abort) aborted_q <= 1'b1;
                    for (int i = 0; i < NUM_ROTORS; i++) begin
                        rem_q[i] <= rem_nxt[i];
                        if (pulse[i]) pos_q[i] <= dir_q[i] ? pos_q[i] + POS_BITS'(1)
                                                           : pos_q[i] - POS_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid) target_q <= cmd_target;
    end

    for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pos
        assign cur_pos[g*POS_BITS +: POS_BITS] = pos_q[g];
    end

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state == S_PLAN) || (state == S_WAIT);
    assign done       = (state == S_DONE);
    assign aborted    = aborted_q;
    assign step_pulse = pulse;
    assign step_dir   = dir_q;

endmodule

// File: tb/tb_rotor_step_sequencer.sv
// Directed bench for rotor_step_sequencer: 2 rotors, 8 faces, 4-clock step pacing, both service modes.
module tb_rotor_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_valid_s, abort;
    logic [5:0] cmd_target;
    logic       cmd_ready, busy, done, aborted;
    logic       cmd_ready_s, busy_s, done_s, aborted_s;
    logic [1:0] step_pulse, step_dir, step_pulse_s, step_dir_s;
    logic [5:0] cur_pos, cur_pos_s;

    int npass = 0;
    int nchk  = 0;

    // Move observation results (k = cycles after the accept cycle T)
    logic [63:0] m0, m1;
    int          done_k;
    logic        ab_v, busy1;
    logic [1:0]  dir_v;
    logic [5:0]  cur_v, cur6;
    logic [1:0]  pacc;

    always #5 clk = ~clk;

    rotor_step_sequencer #(.NUM_ROTORS(2), .POS_BITS(3), .STEP_DIV(4), .SIMULTANEOUS(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .abort(abort), .step_pulse(step_pulse), .step_dir(step_dir),
        .cur_pos(cur_pos), .busy(busy), .done(done), .aborted(aborted));

    rotor_step_sequencer #(.NUM_ROTORS(2), .POS_BITS(3), .STEP_DIV(4), .SIMULTANEOUS(0)) dut_seq (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_s), .cmd_ready(cmd_ready_s),
        .cmd_target(cmd_target), .abort(abort), .step_pulse(step_pulse_s), .step_dir(step_dir_s),
        .cur_pos(cur_pos_s), .busy(busy_s), .done(done_s), .aborted(aborted_s));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Issue one command and observe the move up to its done strobe (bounded at 40 cycles).
    task automatic run_move(input bit seq, input logic [5:0] tgt, input int abort_at, input bit hold);
        logic [1:0] p;
        @(negedge clk);
        cmd_target = tgt;
        if (seq) cmd_valid_s = 1'b1; else cmd_valid = 1'b1;
        #1;
        check("accept_ready", seq ? cmd_ready_s : cmd_ready, 1'b1);
        m0 = '0; m1 = '0; done_k = -1; ab_v = 1'bx; dir_v = 'x; cur_v = 'x; cur6 = 'x; busy1 = 1'bx;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (hold) cmd_target = ~tgt;
            else begin cmd_valid = 1'b0; cmd_valid_s = 1'b0; end
            if (k == abort_at) abort = 1'b1;
            #1;
            p = seq ? step_pulse_s : step_pulse;
            m0[k] = p[0];
            m1[k] = p[1];
            if (k == 1) busy1 = seq ? busy_s : busy;
            if (k == 6) cur6 = seq ? cur_pos_s : cur_pos;
            if (seq ? done_s : done) begin
                done_k = k;
                ab_v   = seq ? aborted_s : aborted;
                dir_v  = seq ? step_dir_s : step_dir;
                cur_v  = seq ? cur_pos_s : cur_pos;
            end
        end
        cmd_valid = 1'b0; cmd_valid_s = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid_s = 1'b0; abort = 1'b0; cmd_target = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_cur", cur_pos, 6'o00);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", step_pulse, 2'b00);
        check("rst_done", {done, aborted}, 2'b00);
        check("rst_dir", step_dir, 2'b00);
        @(negedge clk); rst_n = 1'b1;

        // Forward 3 steps on r0: pulses T+5/9/13, done T+14
        run_move(0, 6'o03, 0, 0);
        check("fwd_busy_plan", busy1, 1'b1);
        check("fwd_m0", m0, 64'h2220);
        check("fwd_m1", m1, 64'h0);
        check("fwd_done_k", done_k, 14);
        check("fwd_dir", dir_v, 2'b11);
        check("fwd_cur", cur_v, 6'o03);
        check("fwd_aborted", ab_v, 1'b0);
        @(negedge clk); #1;
        check("post_done_ready", {cmd_ready, done}, 2'b10);

        // 3 -> 0 is 5 forward, shorter as 3 reverse
        run_move(0, 6'o00, 0, 0);
        check("back_m0", m0, 64'h2220);
        check("back_dir", dir_v, 2'b10);
        check("back_cur", cur_v, 6'o00);

        // Reverse wrap 0 -> 7 -> 6
        run_move(0, 6'o06, 0, 0);
        check("rev_m0", m0, 64'h220);
        check("rev_cur6", cur6, 6'o07);
        check("rev_dir", dir_v, 2'b10);
        check("rev_done_k", done_k, 10);
        check("rev_cur", cur_v, 6'o06);

        // Forward wrap 6 -> 7 -> 0
        run_move(0, 6'o00, 0, 0);
        check("fwrap_m0", m0, 64'h220);
        check("fwrap_dir", dir_v, 2'b11);
        check("fwrap_cur", cur_v, 6'o00);

        // Tie at half-turn goes forward 4
        run_move(0, 6'o04, 0, 0);
        check("tie_m0", m0, 64'h22220);
        check("tie_dir", dir_v, 2'b11);
        check("tie_done_k", done_k, 18);
        check("tie_cur", cur_v, 6'o04);
        run_move(0, 6'o00, 0, 0);
        check("tie_back_cur", cur_v, 6'o00);

        // Simultaneous: r0 +2, r1 -3
        run_move(0, 6'o52, 0, 0);
        check("sim_m0", m0, 64'h220);
        check("sim_m1", m1, 64'h2220);
        check("sim_done_k", done_k, 14);
        check("sim_dir", dir_v, 2'b01);
        check("sim_cur", cur_v, 6'o52);

        // Sequential service: r0 ticks first, then r1
        run_move(1, 6'o52, 0, 0);
        check("seq_m0", m0, 64'h220);
        check("seq_m1", m1, 64'h222000);
        check("seq_done_k", done_k, 22);
        check("seq_dir", dir_v, 2'b01);
        check("seq_cur", cur_v, 6'o52);

        // Reset back to the home face
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst2_cur", cur_pos, 6'o00);
        check("rst2_cur_seq", cur_pos_s, 6'o00);
        rst_n = 1'b1;

        // Abort after first pulse; second tick collides with abort and is suppressed
        run_move(0, 6'o03, 9, 0);
        check("abort_m0", m0, 64'h20);
        check("abort_done_k", done_k, 10);
        check("abort_flag", ab_v, 1'b1);
        check("abort_cur", cur_v, 6'o01);
        @(negedge clk); #1;
        check("abort_flag_held", aborted, 1'b1);

        // Next move plans from face 1 and clears aborted
        run_move(0, 6'o03, 0, 0);
        check("after_abort_m0", m0, 64'h220);
        check("after_abort_flag", ab_v, 1'b0);
        check("after_abort_cur", cur_v, 6'o03);

        // Zero move: done at T+2, no pulses
        run_move(0, 6'o03, 0, 0);
        check("zero_m", {m0, m1}, 128'h0);
        check("zero_done_k", done_k, 2);
        check("zero_cur", cur_v, 6'o03);

        // cmd_valid held (with a different target) during the move is ignored
        run_move(0, 6'o05, 0, 1);
        check("hold_m0", m0, 64'h220);
        check("hold_m1", m1, 64'h0);
        check("hold_cur", cur_v, 6'o05);
        @(negedge clk); #1;
        check("hold_idle", {cmd_ready, busy}, 2'b10);

        // Reset mid-move: 5 -> 1 is a forward half-turn
        @(negedge clk); cmd_target = 6'o01; cmd_valid = 1'b1;
        pacc = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); cmd_valid = 1'b0; #1;
            pacc = pacc | step_pulse;
        end
        check("mid_first_pulse", pacc, 2'b01);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_cur", cur_pos, 6'o00);
        check("mid_rst_pulse", {step_pulse, busy}, 3'b000);
        rst_n = 1'b1;
        pacc = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            pacc = pacc | step_pulse;
        end
        check("mid_no_pulses", pacc, 2'b00);
        check("mid_final", {cur_pos, cmd_ready, busy}, {6'o00, 2'b10});

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
